// File: rtl/data_memory_stage.sv
// Multi-cycle word load/store stage with a LATENCY-cycle busy window and a PC stall.
// Optional macro DMEM_MISALIGN_CHECK_EN flags and suppresses accesses with address[1:0] != 0.
module data_memory_stage #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memReadEnable,
   input  logic        memWriteEnable,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        stall,
   output logic        misaligned
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_reg;
   logic [3:0]       count_reg;
   logic             write_reg;
   logic [31:2]      addr_reg;
   logic [31:0]      data_reg;
   logic [31:0]      mem [DEPTH];

   logic             request;
   logic             in_range;
   logic             last_busy;
   logic             access_ok;
   logic [IDX_W-1:0] index;

   assign request   = memReadEnable | memWriteEnable;
   assign stall     = ((state_reg == IDLE) && request) || (state_reg == BUSY);
   assign index     = addr_reg[IDX_W+1:2];
   assign in_range  = (addr_reg[31:IDX_W+2] == '0);
   assign last_busy = (state_reg == BUSY) && (count_reg == 4'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
   logic bad_reg;
   logic misaligned_reg;

   assign access_ok  = in_range & ~bad_reg;
   assign misaligned = misaligned_reg;

   // Misalignment is judged on the request as seen in IDLE, then held for the access.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bad_reg        <= 1'b0;
         misaligned_reg <= 1'b0;
      end else if ((state_reg == IDLE) && request) begin
         bad_reg <= (address[1:0] != 2'b00);
         if (address[1:0] != 2'b00)
            misaligned_reg <= 1'b1;
      end
   end
`else
   logic unused_addr_bits;

   assign unused_addr_bits = ^address[1:0];
   assign access_ok        = in_range;
   assign misaligned       = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         count_reg <= 4'd0;
         write_reg <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
         readData  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (request) begin
                  state_reg <= BUSY;
                  count_reg <= 4'(LATENCY - 1);
                  // A simultaneous read+write request is a store.
                  write_reg <= memWriteEnable;
                  addr_reg  <= address[31:2];
                  data_reg  <= writeData;
               end
            end
            BUSY: begin
               if (count_reg == 4'd0) begin
                  state_reg <= DONE;
                  if (!write_reg)
                     readData <= access_ok ? mem[index] : '0;
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Reset clears the whole array; a store commits only on the edge leaving BUSY.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (last_busy && write_reg && access_ok) begin
         mem[index] <= data_reg;
      end
   end
endmodule

// File: tb/tb_data_memory_stage.sv
// Self-checking bench for data_memory_stage: vector table plus readData scoreboard queue.
module tb_data_memory_stage;
   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;
   localparam int MEMCYC  = LATENCY + 1;

`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        memReadEnable;
   logic        memWriteEnable;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        stall;
   logic        misaligned;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] exp_q [$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      int          exp_cyc;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [14];

   data_memory_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clock          (clk),
      .reset          (reset_n),
      .memReadEnable  (memReadEnable),
      .memWriteEnable (memWriteEnable),
      .address        (address),
      .writeData      (writeData),
      .readData       (readData),
      .stall          (stall),
      .misaligned     (misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int          n;
      logic [31:0] exp_rd;
      @(negedge clk);
      memReadEnable  = v.rd;
      memWriteEnable = v.wr;
      address        = v.addr;
      writeData      = v.data;
      exp_q.push_back(v.exp_rd);
      #1;
      n = 0;
      while (stall && n < 20) begin
         n++;
         @(posedge clk);
         #1;
         memReadEnable  = 1'b0;
         memWriteEnable = 1'b0;
         #1;
      end
      chk($sformatf("vec%0d_stall_cycles", k), 32'(n), 32'(v.exp_cyc));
      if (exp_q.size() == 0) begin
         chk($sformatf("vec%0d_scoreboard_empty", k), 32'd1, 32'd0);
      end else begin
         exp_rd = exp_q.pop_front();
         chk($sformatf("vec%0d_readData", k), readData, exp_rd);
      end
      chk($sformatf("vec%0d_misaligned", k), 32'(misaligned), 32'(v.exp_mis));
      $display("vec %0d: rd=%b wr=%b addr=%h data=%h -> cycles=%0d readData=%h misaligned=%b",
               k, v.rd, v.wr, v.addr, v.data, n, readData, misaligned);
      memReadEnable  = 1'b0;
      memWriteEnable = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{1'b1, 1'b0, 32'h3C,  32'h0,        32'h0,        MEMCYC, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        MEMCYC, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, MEMCYC, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 0,      1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h100, 32'h1,        32'hDEADBEEF, MEMCYC, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        MEMCYC, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h0,        MEMCYC, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'h10,  32'h11111111, 32'h0,        MEMCYC, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'h11,  32'h12345678, 32'h0,        MEMCYC, MIS_EN};
      vecs[9]  = '{1'b1, 1'b0, 32'h10,  32'h0,
                   MIS_EN ? 32'h11111111 : 32'h12345678,              MEMCYC, MIS_EN};
      vecs[10] = '{1'b1, 1'b1, 32'h8,   32'h55AA55AA,
                   MIS_EN ? 32'h11111111 : 32'h12345678,              MEMCYC, MIS_EN};
      vecs[11] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h55AA55AA, MEMCYC, MIS_EN};
      vecs[12] = '{1'b1, 1'b0, 32'h12,  32'h0,
                   MIS_EN ? 32'h0 : 32'h12345678,                     MEMCYC, MIS_EN};
      vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h0,
                   MIS_EN ? 32'h0 : 32'h12345678,                     0,      MIS_EN};

      reset_n        = 1'b0;
      memReadEnable  = 1'b0;
      memWriteEnable = 1'b0;
      address        = '0;
      writeData      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_readData", readData, 32'h0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_misaligned", 32'(misaligned), 32'd0);
      memReadEnable = 1'b1;
      #1;
      chk("reset_stall_idle_rule", 32'(stall), 32'd1);
      memReadEnable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

      // Reset asserted during the second BUSY cycle of a store.
      @(negedge clk);
      memWriteEnable = 1'b1;
      address        = 32'h20;
      writeData      = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      memWriteEnable = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_busy_stall", 32'(stall), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_stall_drop", 32'(stall), 32'd0);
      chk("midrst_readData", readData, 32'h0);
      chk("midrst_misaligned", 32'(misaligned), 32'd0);
      $display("midrst: stall=%b readData=%h misaligned=%b", stall, readData, misaligned);
      @(negedge clk);
      reset_n = 1'b1;
      v = '{1'b1, 1'b0, 32'h20, 32'h0, 32'h0, MEMCYC, 1'b0};
      run_vec(14, v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
